rom_sdram_loader: RTL

Converts the byte-serial ROM download stream from `data_io` into 16-bit SDRAM write transactions on `sdram` port1. It uses the toggle req/ack handshake. It sits between `data_io` and the `sdram` controller in every Noma-hardware top level and replaces ad-hoc per-top download logic. It pairs even/odd bytes into one word write, buffers bursts in a small FIFO, flushes a trailing partial word at end of download, and reports `rom_loaded` only once every byte has been committed to SDRAM.

---
 rtl/rom_sdram_loader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rom_sdram_loader.sv
// rom_sdram_loader
//   Turns the byte-serial ROM download stream from data_io into 16-bit word
//   writes on an SDRAM port that uses a toggle req/ack handshake. Bytes are
//   paired into words in a hold register, completed words are queued in a
//   small FIFO, and a single issue FSM drains the FIFO one transaction at a
//   time. rom_loaded is raised only after every byte has reached SDRAM.
//
// Ports
//   clk_sys      in   system clock
//   reset        in   synchronous, active-high reset
//   ioctl_downl  in   download active
//   ioctl_index  in   download target index (only ROM_INDEX is accepted)
//   ioctl_wr     in   byte strobe, rising edge = one byte
//   ioctl_addr   in   byte address; [23:1] word address, [0] byte lane
//   ioctl_dout   in   byte data
//   port1_req    out  request toggle
//   port1_ack    in   ack toggle; transaction done when ack == req
//   port1_a      out  word address
//   port1_ds     out  byte enables ([1] = d[15:8], [0] = d[7:0])
//   port1_d      out  write data
//   port1_we     out  write enable (high only while a write is outstanding)
//   busy         out  hold, FIFO or transaction outstanding
//   overflow     out  sticky, a word was dropped because the FIFO was full
//   rom_loaded   out  sticky, download finished and fully written
module rom_sdram_loader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  ROM_INDEX  = 8'd0
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_downl,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port1_we,
   output logic        busy,
   output logic        overflow,
   output logic        rom_loaded
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      r_state;
   logic        r_wr_prev;
   logic        r_downl_prev;
   logic        r_seen;
   logic        r_hold_vld;
   logic [22:0] r_hold_a;
   logic [15:0] r_hold_d;
   logic [1:0]  r_hold_ds;
   logic [22:0] r_fifo_a  [FIFO_DEPTH];
   logic [15:0] r_fifo_d  [FIFO_DEPTH];
   logic [1:0]  r_fifo_ds [FIFO_DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;

   logic        w_accept;
   logic        w_fall;
   logic        w_rise;
   logic [22:0] w_waddr;
   logic [1:0]  w_lane_ds;
   logic [15:0] w_lane_d;
   logic [1:0]  w_merge_ds;
   logic [15:0] w_merge_d;
   logic        w_push;
   logic [22:0] w_push_a;
   logic [15:0] w_push_d;
   logic [1:0]  w_push_ds;
   logic        w_hold_vld_n;
   logic [22:0] w_hold_a_n;
   logic [15:0] w_hold_d_n;
   logic [1:0]  w_hold_ds_n;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push_ok;
   logic        w_drop;
   logic        w_unused_addr_msb;

   assign w_unused_addr_msb = ioctl_addr[24];

   assign w_accept  = ioctl_wr && !r_wr_prev && ioctl_downl && (ioctl_index == ROM_INDEX);
   assign w_fall    = r_downl_prev && !ioctl_downl;
   assign w_rise    = !r_downl_prev && ioctl_downl;
   assign w_waddr   = ioctl_addr[23:1];
   assign w_lane_ds = ioctl_addr[0] ? 2'b10 : 2'b01;
   assign w_lane_d  = ioctl_addr[0] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
   assign w_merge_ds = r_hold_ds | w_lane_ds;
   assign w_merge_d  = ioctl_addr[0] ? {ioctl_dout, r_hold_d[7:0]} : {r_hold_d[15:8], ioctl_dout};

   // Hold register next state and the (at most one) FIFO push per cycle.
   always_comb begin
      w_push       = 1'b0;
      w_push_a     = r_hold_a;
      w_push_d     = r_hold_d;
      w_push_ds    = r_hold_ds;
      w_hold_vld_n = r_hold_vld;
      w_hold_a_n   = r_hold_a;
      w_hold_d_n   = r_hold_d;
      w_hold_ds_n  = r_hold_ds;
      if (w_accept) begin
         if (r_hold_vld && (r_hold_a == w_waddr) && ((r_hold_ds & w_lane_ds) == 2'b00)) begin
            if (w_merge_ds == 2'b11) begin
               // Word complete: push the merged word directly, hold empties.
               w_push       = 1'b1;
               w_push_d     = w_merge_d;
               w_push_ds    = 2'b11;
               w_hold_vld_n = 1'b0;
            end else begin
               w_hold_d_n  = w_merge_d;
               w_hold_ds_n = w_merge_ds;
            end
         end else begin
            // New word: evict any partial word first, then start a new one.
            w_push       = r_hold_vld;
            w_hold_vld_n = 1'b1;
            w_hold_a_n   = w_waddr;
            w_hold_d_n   = w_lane_d;
            w_hold_ds_n  = w_lane_ds;
         end
      end else if (w_fall && r_hold_vld) begin
         // End of download: flush the trailing partial word.
         w_push       = 1'b1;
         w_hold_vld_n = 1'b0;
      end
   end

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop     = (r_state == S_IDLE) && !w_empty && (port1_req == port1_ack);
   // A pop in the same cycle frees the slot, so a push while full still fits.
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;
   assign busy      = r_hold_vld || !w_empty || (r_state == S_WAIT);

   always_ff @(posedge clk_sys) begin
      if (w_push_ok) begin
         r_fifo_a[r_wptr[AW-1:0]]  <= w_push_a;
         r_fifo_d[r_wptr[AW-1:0]]  <= w_push_d;
         r_fifo_ds[r_wptr[AW-1:0]] <= w_push_ds;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         // Sample live strobes so a level held through reset is not seen as an edge.
         r_wr_prev    <= ioctl_wr;
         r_downl_prev <= ioctl_downl;
         r_seen       <= 1'b0;
         r_hold_vld   <= 1'b0;
         r_hold_a     <= '0;
         r_hold_d     <= '0;
         r_hold_ds    <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_state      <= S_IDLE;
         port1_req    <= port1_ack;
         port1_a      <= '0;
         port1_ds     <= '0;
         port1_d      <= '0;
         port1_we     <= 1'b0;
         overflow     <= 1'b0;
         rom_loaded   <= 1'b0;
      end else begin
         r_wr_prev    <= ioctl_wr;
         r_downl_prev <= ioctl_downl;
         r_hold_vld   <= w_hold_vld_n;
         r_hold_a     <= w_hold_a_n;
         r_hold_d     <= w_hold_d_n;
         r_hold_ds    <= w_hold_ds_n;
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop)     r_rptr <= r_rptr + 1'b1;

         if (w_drop)      overflow <= 1'b1;
         else if (w_rise) overflow <= 1'b0;

         if (w_fall)      r_seen <= 1'b1;
         else if (w_rise) r_seen <= 1'b0;

         if (w_rise)                                   rom_loaded <= 1'b0;
         else if (!ioctl_downl && !busy && r_seen)     rom_loaded <= 1'b1;

         case (r_state)
            S_IDLE: begin
               port1_we <= 1'b0;
               if (w_pop) begin
                  port1_a   <= r_fifo_a[r_rptr[AW-1:0]];
                  port1_ds  <= r_fifo_ds[r_rptr[AW-1:0]];
                  port1_d   <= r_fifo_d[r_rptr[AW-1:0]];
                  port1_we  <= 1'b1;
                  port1_req <= ~port1_req;
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (port1_ack == port1_req) begin
                  port1_we <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
